// File: rtl/rf_cmd_ctrl_pkg.sv
// Shared constants and state encoding for the rf_cmd_ctrl register-file initiator.
package rf_cmd_ctrl_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_ADDR_W = 4;

    localparam logic [7:0] WR_CMD = 8'hAA;
    localparam logic [7:0] RD_CMD = 8'hBB;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_SEND = 3'd5
    } state_e;

endpackage

// File: rtl/rf_cmd_ctrl_frame_timer.sv
// Saturating cycle counter with clear/enable; o_expire flags the LIMIT-th counted cycle.
module frame_timer #(
    parameter int LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_expire;

    assign w_expire = (r_cnt == LAST);
    assign o_expire = w_expire;

    // Count enabled cycles, holding at LAST until cleared.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_en && !w_expire) begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/rf_cmd_ctrl.sv
// Register-file initiator: decodes UART command frames into WrEn/RdEn and returns read data to TX.
// Optional inter-byte frame timeout is built when FRAME_TIMEOUT_EN is defined.
module rf_cmd_ctrl
    import rf_cmd_ctrl_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int RD_WAIT_MAX = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  RX_P_DATA,
    input  logic              RX_D_VLD,
    output logic              WrEn,
    output logic              RdEn,
    output logic [ADDR_W-1:0] Address,
    output logic [WIDTH-1:0]  WrData,
    input  logic [WIDTH-1:0]  RdData,
    input  logic              RdData_valid,
    output logic [WIDTH-1:0]  TX_P_DATA,
    output logic              TX_D_VLD,
    input  logic              TX_BUSY,
    output logic              CMD_ERR
);

    if (TIMEOUT_CYC < 2 || RD_WAIT_MAX < 1) begin : g_param_check
        $error("rf_cmd_ctrl: TIMEOUT_CYC must be >= 2 and RD_WAIT_MAX >= 1");
    end

    state_e            r_state, w_state_nxt;
    logic              r_wr_en, w_wr_en;
    logic              r_rd_en, w_rd_en;
    logic              r_tx_vld, w_tx_vld;
    logic              r_cmd_err, w_cmd_err;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [WIDTH-1:0]  r_wr_data, w_wr_data;
    logic [WIDTH-1:0]  r_tx_data, w_tx_data;
    logic              w_addr_ok;
    logic              w_rd_expire;
    logic              w_frame_to;

    assign w_addr_ok = (RX_P_DATA[WIDTH-1:ADDR_W] == {(WIDTH-ADDR_W){1'b0}});

    frame_timer #(.LIMIT(RD_WAIT_MAX)) u_rd_timer (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_clr   (r_state != RD_WAIT),
        .i_en    (r_state == RD_WAIT),
        .o_expire(w_rd_expire)
    );

`ifdef FRAME_TIMEOUT_EN
    logic w_in_frame;
    assign w_in_frame = (r_state == WR_ADDR) || (r_state == WR_DATA) || (r_state == RD_ADDR);

    // Entry into a frame state always coincides with a received byte, so RX_D_VLD covers both clears.
    frame_timer #(.LIMIT(TIMEOUT_CYC)) u_frame_timer (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_clr   (!w_in_frame || RX_D_VLD),
        .i_en    (w_in_frame),
        .o_expire(w_frame_to)
    );
`else
    assign w_frame_to = 1'b0;
`endif

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_tx_vld    = 1'b0;
        w_cmd_err   = 1'b0;
        w_addr      = r_addr;
        w_wr_data   = r_wr_data;
        w_tx_data   = r_tx_data;
        case (r_state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WIDTH'(WR_CMD)) begin
                        w_state_nxt = WR_ADDR;
                    end else if (RX_P_DATA == WIDTH'(RD_CMD)) begin
                        w_state_nxt = RD_ADDR;
                    end else begin
                        w_cmd_err = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WR_ADDR, RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (w_addr_ok) begin
                        w_addr = RX_P_DATA[ADDR_W-1:0];
                        if (r_state == RD_ADDR) begin
                            w_rd_en     = 1'b1;
                            w_state_nxt = RD_WAIT;
                        end else begin
                            w_state_nxt = WR_DATA;
                        end
                    end else begin
                        w_cmd_err   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else if (w_frame_to) begin
                    w_cmd_err   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    w_wr_data   = RX_P_DATA;
                    w_wr_en     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_frame_to) begin
                    w_cmd_err   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WR_DATA;
                end
            end
            RD_WAIT: begin
                w_cmd_err = RX_D_VLD;
                // Data with an idle transmitter goes straight out, keeping RdData_valid->TX_D_VLD at one cycle.
                if (RdData_valid) begin
                    w_tx_data = RdData;
                    if (!TX_BUSY) begin
                        w_tx_vld    = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = TX_SEND;
                    end
                end else if (w_rd_expire) begin
                    w_cmd_err   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RD_WAIT;
                end
            end
            TX_SEND: begin
                w_cmd_err = RX_D_VLD;
                if (!TX_BUSY) begin
                    w_tx_vld    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = TX_SEND;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_tx_vld  <= 1'b0;
            r_cmd_err <= 1'b0;
            r_addr    <= {ADDR_W{1'b0}};
            r_wr_data <= {WIDTH{1'b0}};
            r_tx_data <= {WIDTH{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_wr_en   <= w_wr_en;
            r_rd_en   <= w_rd_en;
            r_tx_vld  <= w_tx_vld;
            r_cmd_err <= w_cmd_err;
            r_addr    <= w_addr;
            r_wr_data <= w_wr_data;
            r_tx_data <= w_tx_data;
        end
    end

    assign WrEn      = r_wr_en;
    assign RdEn      = r_rd_en;
    assign Address   = r_addr;
    assign WrData    = r_wr_data;
    assign TX_P_DATA = r_tx_data;
    assign TX_D_VLD  = r_tx_vld;
    assign CMD_ERR   = r_cmd_err;

endmodule

// File: doc/rf_cmd_ctrl.md
Name: rf_cmd_ctrl

Overview:
- Register-file initiator: decodes byte-wide command frames from the UART RX parallel interface and drives the register file write/read port (WrEn, RdEn, Address, WrData).
- Returns read data to the UART TX parallel interface.
- Sits between the RX deserialiser, the register file and the TX serialiser, all in the same clock domain.

Parameters:
- WIDTH, 8, data/byte width of RX, TX and register file data.
- ADDR_W, 4, register file address width.
- RD_WAIT_MAX, 4, cycles to wait for RdData_valid after RdEn before aborting.
- TIMEOUT_CYC, 1024, inter-byte frame timeout in cycles (used only with FRAME_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- RX_P_DATA  in  WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA is valid in that cycle.
- WrEn  out  1  register file write strobe, one cycle.
- RdEn  out  1  register file read strobe, one cycle.
- Address  out  ADDR_W  register file address.
- WrData  out  WIDTH  register file write data.
- RdData  in  WIDTH  register file read data.
- RdData_valid  in  1  register file read-data qualifier.
- TX_P_DATA  out  WIDTH  byte to transmit.
- TX_D_VLD  out  1  one-cycle transmit request.
- TX_BUSY  in  1  transmitter busy; no TX_D_VLD while high.
- CMD_ERR  out  1  one-cycle error pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; address/data holding registers 0; RST high forces this immediately from any state, aborting any frame in progress.
- All outputs are registered. WrEn and RdEn are never high in the same cycle.
- Frame formats:
  - Write: WR_CMD = 0xAA, then addr byte, then data byte.
  - Read: RD_CMD = 0xBB, then addr byte.
- States:
  - IDLE:
    - RX_D_VLD with 0xAA -> WR_ADDR.
    - RX_D_VLD with 0xBB -> RD_ADDR.
    - RX_D_VLD with any other byte -> CMD_ERR pulse; stay in IDLE.
  - WR_ADDR, on RX_D_VLD:
    - If byte[WIDTH-1:ADDR_W] != 0: CMD_ERR pulse -> IDLE.
    - Else latch Address = byte[ADDR_W-1:0] -> WR_DATA.
  - WR_DATA, on RX_D_VLD: next cycle WrEn=1 for exactly one cycle with WrData = byte and Address held -> IDLE.
  - RD_ADDR, on RX_D_VLD:
    - Same range check as WR_ADDR.
    - Valid: next cycle RdEn=1 for one cycle with Address -> RD_WAIT.
    - Out of range: CMD_ERR pulse -> IDLE.
  - RD_WAIT:
    - First cycle with RdData_valid=1: latch RdData into TX holding register -> TX_SEND.
    - Wait counter reaches RD_WAIT_MAX without RdData_valid: CMD_ERR pulse -> IDLE.
  - TX_SEND: first cycle with TX_BUSY=0: TX_D_VLD=1 for one cycle with TX_P_DATA = held byte -> IDLE. Waits indefinitely while TX_BUSY=1.
- Overrun: RX_D_VLD in RD_WAIT or TX_SEND drops the byte, pulses CMD_ERR, and does not change state.
- Latency:
  - Data byte RX_D_VLD -> WrEn: 1 cycle.
  - Addr byte RX_D_VLD -> RdEn: 1 cycle.
  - RdData_valid -> TX_D_VLD: 1 cycle if TX_BUSY=0.
- Back-to-back frames are accepted: a command byte arriving the cycle after WrEn is decoded normally.

Optional Feature:
- Macro: FRAME_TIMEOUT_EN.
- Defined: in WR_ADDR, WR_DATA and RD_ADDR, a counter clears on each RX_D_VLD and on state entry. When it reaches TIMEOUT_CYC-1 with no byte received: CMD_ERR pulse and return to IDLE; partial frame discarded, no WrEn/RdEn issued.
- Not defined: these states wait indefinitely; counter logic is absent.

Decomposition:
- Shared package: WR_CMD (0xAA), RD_CMD (0xBB), state enumeration (IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND), default WIDTH/ADDR_W.
- One sub-module: frame_timer. Clear/enable inputs and an expire output; reused for the RD_WAIT counter and, under FRAME_TIMEOUT_EN, the inter-byte timeout.

Test Plan:
- Write: RX bytes 0xAA, 0x05, 0x3C -> single WrEn pulse, Address=5, WrData=0x3C, one cycle after third RX_D_VLD; CMD_ERR stays 0.
- Read: RX 0xBB, 0x02; responder returns RdData=0x81 with RdData_valid one cycle after RdEn; TX_BUSY=0 -> TX_D_VLD pulse with TX_P_DATA=0x81.
- TX back-pressure: same read with TX_BUSY=1 for 10 cycles -> TX_D_VLD delayed until the first cycle TX_BUSY=0; byte 0x81 unchanged.
- Errors:
  - RX 0x55 in IDLE -> CMD_ERR pulse, no strobes.
  - RX 0xAA, 0x1F -> CMD_ERR pulse, no WrEn.
  - RdEn with no RdData_valid for 4 cycles -> CMD_ERR, back to IDLE.
- Overrun/reset:
  - RX byte during TX_SEND -> CMD_ERR, read byte still sent.
  - RST asserted after 0xAA, 0x03 -> all outputs 0, following 0xBB frame decodes normally.
- FRAME_TIMEOUT_EN, TIMEOUT_CYC=16: RX 0xAA then silence for 16 cycles -> CMD_ERR; later 0x03 treated as IDLE byte -> CMD_ERR.
